// File: rtl/adder_rs.sv
// Adder reservation station: dual in-order dispatch, CDB snoop, oldest-ready issue to the adder FU.
// Accepted ready operands issue the cycle after dispatch; dispatch stalls when full; issue holds until IssueReady.
module adder_rs #(
  parameter int DEPTH    = 3,
  parameter int DATAW    = 16,
  parameter int TAGW     = 3,
  parameter int TAG_BASE = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         disp_valid0_i,
  input  logic                         disp_valid1_i,
  input  logic [15:0]                  disp_inst0_i,
  input  logic [15:0]                  disp_inst1_i,
  input  logic [DATAW-1:0]             disp_vj0_i,
  input  logic [DATAW-1:0]             disp_vk0_i,
  input  logic [DATAW-1:0]             disp_vj1_i,
  input  logic [DATAW-1:0]             disp_vk1_i,
  input  logic [TAGW-1:0]              disp_qj0_i,
  input  logic [TAGW-1:0]              disp_qk0_i,
  input  logic [TAGW-1:0]              disp_qj1_i,
  input  logic [TAGW-1:0]              disp_qk1_i,
  output logic                         disp_ready0_o,
  output logic                         disp_ready1_o,
  output logic [TAGW-1:0]              disp_tag0_o,
  output logic [TAGW-1:0]              disp_tag1_o,
  input  logic                         cdb_valid_i,
  input  logic [TAGW-1:0]              cdb_tag_i,
  input  logic [DATAW-1:0]             cdb_data_i,
  output logic                         issue_valid_o,
  input  logic                         issue_ready_i,
  output logic [3:0]                   issue_op_o,
  output logic [DATAW-1:0]             issue_vj_o,
  output logic [DATAW-1:0]             issue_vk_o,
  output logic [5:0]                   issue_imm_o,
  output logic [TAGW-1:0]              issue_tag_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int IDXW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);
  localparam logic [TAGW-1:0] TB = TAG_BASE[TAGW-1:0];

  typedef struct packed {
    logic             busy;
    logic [3:0]       op;
    logic [5:0]       imm;
    logic [DATAW-1:0] vj;
    logic [TAGW-1:0]  qj;
    logic [DATAW-1:0] vk;
    logic [TAGW-1:0]  qk;
    logic [3:0]       age;
  } ent_t;

  ent_t            ent_q [DEPTH];
  ent_t            ent_d [DEPTH];
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [IDXW-1:0] free0, free1, sel;
  logic            has_free0, has_free1, sel_vld;
  logic [3:0]      best_age;
  logic            acc0, acc1, fire;

  logic unused_regs;
  assign unused_regs = ^{disp_inst0_i[9:4], disp_inst1_i[9:4]};

  function automatic logic cdb_hit(input logic [TAGW-1:0] q);
    return cdb_valid_i && (q != '0) && (q == cdb_tag_i);
  endfunction

  function automatic ent_t mk_ent(input logic [3:0] op, input logic [5:0] imm,
                                  input logic [DATAW-1:0] vj, input logic [DATAW-1:0] vk,
                                  input logic [TAGW-1:0] qj, input logic [TAGW-1:0] qk,
                                  input logic [3:0] age);
    ent_t e;
    e.busy = 1'b1;
    e.op   = op;
    e.imm  = imm;
    e.vj   = cdb_hit(qj) ? cdb_data_i : vj;
    e.qj   = cdb_hit(qj) ? '0 : qj;
    e.vk   = cdb_hit(qk) ? cdb_data_i : vk;
    e.qk   = cdb_hit(qk) ? '0 : qk;
    e.age  = age;
    return e;
  endfunction

  // Allocation looks only at current busy bits, so a slot freed by this cycle's issue waits a cycle.
  always_comb begin
    free0 = '0;
    free1 = '0;
    has_free0 = 1'b0;
    has_free1 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!ent_q[i].busy) begin
        if (!has_free0) begin
          free0 = IDXW'(i);
          has_free0 = 1'b1;
        end else if (!has_free1) begin
          free1 = IDXW'(i);
          has_free1 = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel = '0;
    sel_vld = 1'b0;
    best_age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].busy && ent_q[i].qj == '0 && ent_q[i].qk == '0 &&
          (!sel_vld || ent_q[i].age > best_age)) begin
        sel = IDXW'(i);
        best_age = ent_q[i].age;
        sel_vld = 1'b1;
      end
    end
  end

  assign disp_ready0_o = (cnt_q != CNTW'(DEPTH));
  assign disp_ready1_o = (cnt_q <= CNTW'(DEPTH-2));
  assign disp_tag0_o   = TB + TAGW'(free0);
  assign disp_tag1_o   = TB + TAGW'(free1);

  assign acc0 = disp_valid0_i && disp_ready0_o && (disp_inst0_i[3:0] <= 4'd2);
  assign acc1 = disp_valid1_i && acc0 && disp_ready1_o && (disp_inst1_i[3:0] <= 4'd2);
  assign fire = sel_vld && issue_ready_i;

  assign issue_valid_o = sel_vld;
  assign issue_op_o    = sel_vld ? ent_q[sel].op  : '0;
  assign issue_vj_o    = sel_vld ? ent_q[sel].vj  : '0;
  assign issue_vk_o    = sel_vld ? ent_q[sel].vk  : '0;
  assign issue_imm_o   = sel_vld ? ent_q[sel].imm : '0;
  assign issue_tag_o   = TB + TAGW'(sel);
  assign count_o       = cnt_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].busy) begin
        if (cdb_hit(ent_q[i].qj)) begin
          ent_d[i].vj = cdb_data_i;
          ent_d[i].qj = '0;
        end
        if (cdb_hit(ent_q[i].qk)) begin
          ent_d[i].vk = cdb_data_i;
          ent_d[i].qk = '0;
        end
        if (ent_q[i].age != 4'hF) ent_d[i].age = ent_q[i].age + 4'd1;
      end
      if (fire && sel == IDXW'(i)) ent_d[i].busy = 1'b0;
    end
    if (acc0) ent_d[free0] = mk_ent(disp_inst0_i[3:0], disp_inst0_i[15:10], disp_vj0_i,
                                    disp_vk0_i, disp_qj0_i, disp_qk0_i, 4'd1);
    if (acc1) ent_d[free1] = mk_ent(disp_inst1_i[3:0], disp_inst1_i[15:10], disp_vj1_i,
                                    disp_vk1_i, disp_qj1_i, disp_qk1_i, 4'd0);
  end

  assign cnt_d = cnt_q + CNTW'(acc0) + CNTW'(acc1) - CNTW'(fire);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_adder_rs.sv
// Bench for adder_rs: directed scenarios then random traffic, all checked against a spec-level model.
module tb_adder_rs;
  localparam int DEPTH = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dv0, dv1, cv, ir;
  logic [15:0] di0, di1, vj0, vk0, vj1, vk1, cd;
  logic [2:0]  qj0, qk0, qj1, qk1, ct;
  logic        rdy0, rdy1, iv;
  logic [2:0]  tag0, tag1, itag;
  logic [3:0]  iop;
  logic [15:0] ivj, ivk;
  logic [5:0]  iimm;
  logic [1:0]  cnt;

  int errors = 0;
  int checks = 0;

  bit          m_busy [DEPTH];
  logic [3:0]  m_op   [DEPTH];
  logic [5:0]  m_imm  [DEPTH];
  logic [15:0] m_vj   [DEPTH];
  logic [15:0] m_vk   [DEPTH];
  logic [2:0]  m_qj   [DEPTH];
  logic [2:0]  m_qk   [DEPTH];
  int          m_age  [DEPTH];

  always #5 clk = ~clk;

  adder_rs dut (
    .clk(clk), .rst_n(rst_n),
    .disp_valid0_i(dv0), .disp_valid1_i(dv1),
    .disp_inst0_i(di0), .disp_inst1_i(di1),
    .disp_vj0_i(vj0), .disp_vk0_i(vk0), .disp_vj1_i(vj1), .disp_vk1_i(vk1),
    .disp_qj0_i(qj0), .disp_qk0_i(qk0), .disp_qj1_i(qj1), .disp_qk1_i(qk1),
    .disp_ready0_o(rdy0), .disp_ready1_o(rdy1),
    .disp_tag0_o(tag0), .disp_tag1_o(tag1),
    .cdb_valid_i(cv), .cdb_tag_i(ct), .cdb_data_i(cd),
    .issue_valid_o(iv), .issue_ready_i(ir),
    .issue_op_o(iop), .issue_vj_o(ivj), .issue_vk_o(ivk),
    .issue_imm_o(iimm), .issue_tag_o(itag), .count_o(cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    dv0 = 0; dv1 = 0; cv = 0; ct = 0; cd = 0;
    di0 = 0; di1 = 0; vj0 = 0; vk0 = 0; vj1 = 0; vk1 = 0;
    qj0 = 0; qk0 = 0; qj1 = 0; qk1 = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_busy[i] = 0; m_op[i] = 0; m_imm[i] = 0; m_vj[i] = 0; m_vk[i] = 0;
      m_qj[i] = 0; m_qk[i] = 0; m_age[i] = 0;
    end
  endtask

  // n-th free entry in index order, -1 if there is none
  function automatic int free_idx(input int n);
    int seen = 0;
    for (int i = 0; i < DEPTH; i++)
      if (!m_busy[i]) begin
        if (seen == n) return i;
        seen++;
      end
    return -1;
  endfunction

  // oldest operand-complete entry; among equal ages the lowest index
  function automatic int pick();
    int oldest = -1;
    for (int i = 0; i < DEPTH; i++)
      if (m_busy[i] && m_qj[i] == 0 && m_qk[i] == 0 && m_age[i] > oldest) oldest = m_age[i];
    for (int i = 0; i < DEPTH; i++)
      if (m_busy[i] && m_qj[i] == 0 && m_qk[i] == 0 && m_age[i] == oldest) return i;
    return -1;
  endfunction

  function automatic int occupied();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic bit bus_hit(input logic [2:0] q);
    return cv && q != 0 && q == ct;
  endfunction

  task automatic alloc(input int e, input logic [15:0] inst, input logic [15:0] vj,
                       input logic [15:0] vk, input logic [2:0] qj, input logic [2:0] qk,
                       input int age);
    m_busy[e] = 1;
    m_op[e]   = inst[3:0];
    m_imm[e]  = inst[15:10];
    m_vj[e]   = bus_hit(qj) ? cd : vj;
    m_qj[e]   = bus_hit(qj) ? 3'd0 : qj;
    m_vk[e]   = bus_hit(qk) ? cd : vk;
    m_qk[e]   = bus_hit(qk) ? 3'd0 : qk;
    m_age[e]  = age;
  endtask

  task automatic model_edge();
    int f0, f1, p;
    bit a0, a1;
    f0 = free_idx(0);
    f1 = free_idx(1);
    p  = pick();
    a0 = dv0 && f0 >= 0 && di0[3:0] <= 4'd2;
    a1 = dv1 && a0 && f1 >= 0 && di1[3:0] <= 4'd2;
    for (int i = 0; i < DEPTH; i++)
      if (m_busy[i]) begin
        if (bus_hit(m_qj[i])) begin m_vj[i] = cd; m_qj[i] = 0; end
        if (bus_hit(m_qk[i])) begin m_vk[i] = cd; m_qk[i] = 0; end
        m_age[i] = (m_age[i] >= 15) ? 15 : m_age[i] + 1;
      end
    if (p >= 0 && ir) m_busy[p] = 0;
    if (a0) alloc(f0, di0, vj0, vk0, qj0, qk0, 1);
    if (a1) alloc(f1, di1, vj1, vk1, qj1, qk1, 0);
  endtask

  task automatic chk_model();
    int f0, f1, p;
    f0 = free_idx(0);
    f1 = free_idx(1);
    p  = pick();
    chk("count", cnt, occupied());
    chk("disp_ready0", rdy0, f0 >= 0);
    chk("disp_ready1", rdy1, f1 >= 0);
    if (f0 >= 0) chk("disp_tag0", tag0, 1 + f0);
    if (f1 >= 0) chk("disp_tag1", tag1, 1 + f1);
    chk("issue_valid", iv, p >= 0);
    if (p >= 0) begin
      chk("issue_tag", itag, 1 + p);
      chk("issue_op", iop, m_op[p]);
      chk("issue_vj", ivj, m_vj[p]);
      chk("issue_vk", ivk, m_vk[p]);
      chk("issue_imm", iimm, m_imm[p]);
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [2:0] rnd_tag();
    return ($urandom_range(0, 3) < 2) ? 3'd0 : 3'($urandom_range(1, 7));
  endfunction

  function automatic logic [15:0] rnd_inst();
    logic [3:0] op;
    op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(3, 15)) : 4'($urandom_range(0, 2));
    return {12'($urandom), op};
  endfunction

  initial begin
    idle();
    ir = 0;
    rst_n = 0;
    model_reset();
    #2;
    chk("rst_count", cnt, 0);
    chk("rst_issue_valid", iv, 0);
    chk("rst_issue_tag", itag, 1);
    chk("rst_issue_vj", ivj, 0);
    chk("rst_tag0", tag0, 1);
    chk("rst_tag1", tag1, 2);
    chk("rst_ready0", rdy0, 1);
    chk("rst_ready1", rdy1, 1);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // dual dispatch, both operand-complete
    ir = 1;
    dv0 = 1; di0 = 16'h0021; vj0 = 5; vk0 = 3;
    dv1 = 1; di1 = 16'h0041; vj1 = 7; vk1 = 2;
    chk("dual_tag0", tag0, 1);
    chk("dual_tag1", tag1, 2);
    step();
    idle();
    chk("dual_first_tag", itag, 1);
    chk("dual_first_vj", ivj, 5);
    chk("dual_first_vk", ivk, 3);
    step();
    chk("dual_second_tag", itag, 2);
    chk("dual_second_op", iop, 4'b0001);
    step();
    chk("dual_drained", cnt, 0);

    // operand resolved by CDB two cycles after dispatch
    dv0 = 1; di0 = 16'h0000; qj0 = 5; vk0 = 1;
    step();
    idle();
    chk("cdb_wait0", iv, 0);
    step();
    chk("cdb_wait1", iv, 0);
    cv = 1; ct = 5; cd = 16'h00AA;
    chk("cdb_no_fwd", iv, 0);
    step();
    idle();
    chk("cdb_ready", iv, 1);
    chk("cdb_vj", ivj, 16'h00AA);
    step();

    // dispatch-time bypass of a same-cycle broadcast
    dv0 = 1; di0 = 16'h0000; vj0 = 4; qk0 = 6;
    cv = 1; ct = 6; cd = 16'd9;
    step();
    idle();
    chk("bypass_valid", iv, 1);
    chk("bypass_vk", ivk, 9);
    step();

    // fill, reject when full, free one slot
    ir = 0;
    dv0 = 1; di0 = 16'h0400; vj0 = 1; dv1 = 1; di1 = 16'h0801; vj1 = 2;
    step();
    idle();
    dv0 = 1; di0 = 16'h0C02; vj0 = 3;
    step();
    chk("full_count", cnt, 3);
    chk("full_ready0", rdy0, 0);
    chk("full_ready1", rdy1, 0);
    dv0 = 1; di0 = 16'h0000; vj0 = 16'hDEAD;
    step();
    idle();
    chk("full_reject", cnt, 3);
    ir = 1;
    step();
    chk("free_count", cnt, 2);
    chk("free_ready0", rdy0, 1);
    step();
    step();

    // younger resolves first, older still issues first
    ir = 0;
    dv0 = 1; di0 = 16'h0000; qj0 = 5; vk0 = 1;
    dv1 = 1; di1 = 16'h0001; qj1 = 6; vk1 = 2;
    step();
    idle();
    step();
    cv = 1; ct = 6; cd = 16'h0011;
    step();
    cv = 1; ct = 5; cd = 16'h0022;
    step();
    idle();
    chk("age_old_tag", itag, 1);
    chk("age_old_vj", ivj, 16'h0022);
    ir = 1;
    step();
    chk("age_young_tag", itag, 2);
    chk("age_young_vj", ivj, 16'h0011);
    step();

    // asynchronous reset mid-stream
    ir = 0;
    dv0 = 1; di0 = 16'h0000; vj0 = 1; dv1 = 1; di1 = 16'h0001; vj1 = 2;
    step();
    idle();
    #2;
    rst_n = 0;
    #1;
    chk("arst_count", cnt, 0);
    chk("arst_issue_valid", iv, 0);
    chk("arst_tag0", tag0, 1);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    dv0 = 1; di0 = 16'h0002; vj0 = 16'h0033;
    step();
    idle();
    chk("arst_resume_tag", itag, 1);
    chk("arst_resume_op", iop, 4'd2);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      dv0 = ($urandom_range(0, 3) != 0);
      dv1 = $urandom_range(0, 1);
      di0 = rnd_inst(); di1 = rnd_inst();
      vj0 = 16'($urandom); vk0 = 16'($urandom);
      vj1 = 16'($urandom); vk1 = 16'($urandom);
      qj0 = rnd_tag(); qk0 = rnd_tag(); qj1 = rnd_tag(); qk1 = rnd_tag();
      cv = $urandom_range(0, 1);
      ct = 3'($urandom_range(0, 7));
      cd = 16'($urandom);
      ir = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
